// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Stopwatch sequencer: owns the TICK_HZ timebase (a one-cycle enable, not a
//   derived clock) and runs the IDLE/RUN/PAUSE/LAP state machine over a BCD
//   mm:ss.cc counter. Sits between the debounced buttons and the 7-segment
//   display driver.
//
//   Assumes CLK_HZ is an exact multiple of TICK_HZ with CLK_HZ/TICK_HZ >= 2.
//
// Ports
//   CLOCK        in   1   system clock, rising edge
//   RESET_n      in   1   asynchronous active-low reset
//   start_stop   in   1   debounced single-cycle pulse
//   lap          in   1   debounced single-cycle pulse
//   clear        in   1   debounced single-cycle pulse
//   tick_100hz   out  1   one-cycle pulse per counted tick (RUN/LAP only)
//   display_bcd  out  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
//   running      out  1   high in RUN and LAP
//   lap_active   out  1   high in LAP
//   overflow     out  1   sticky, set on wrap from 59:59.99
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic        CLOCK,
    input  logic        RESET_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic        tick_100hz,
    output logic [23:0] display_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [23:0]    cnt_q, cnt_d;
    logic [23:0]    snap_q, snap_d;
    logic           ovf_q, ovf_d;
    logic           tick_q, tick_d;
    logic [24:0]    inc_res;
    logic           count_en;

    // Increment a packed mm:ss.cc BCD value by one centisecond.
    // Result is {wrap, value}; wrap is the carry out of min_t (59:59.99 -> 0).
    // Digit index 0 is cs_u; tens-of-seconds (3) and tens-of-minutes (5)
    // roll at 5, every other digit at 9.
    function automatic logic [24:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  d;
        logic [3:0]  lim;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d   = c[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (d == lim) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return {carry, r};
    endfunction

    assign inc_res  = bcd_inc(cnt_q);
    assign count_en = (state_q == S_RUN) || (state_q == S_LAP);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;
        tick_d  = 1'b0;

        // Timebase: gated by state so a pause keeps the partial interval.
        // A button pulse on a tick edge still lets that tick count.
        if (count_en) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick_d  = 1'b1;
                cnt_d   = inc_res[23:0];
                if (inc_res[24]) begin
                    ovf_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Priority clear > start_stop > lap; inputs not meaningful in a
        // state are simply not looked at there.
        case (state_q)
            S_IDLE: begin
                if (start_stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap) begin
                    state_d = S_LAP;
                    snap_d  = cnt_q;    // pre-increment value if a tick coincides
                end
            end
            S_LAP: begin
                if (start_stop) begin
                    state_d = S_PAUSE;
                end else if (lap) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                    ovf_d   = 1'b0;
                end else if (start_stop) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            snap_q  <= '0;
            ovf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
            tick_q  <= tick_d;
        end
    end

    // All outputs are registers or a mux of registers.
    assign tick_100hz  = tick_q;
    assign running     = count_en;
    assign lap_active  = (state_q == S_LAP);
    assign display_bcd = (state_q == S_LAP) ? snap_q : cnt_q;
    assign overflow    = ovf_q;

endmodule
